// File: rtl/wb_arbiter_2m.sv
// Round-robin two-master Wishbone arbiter; a grant is held for the master's whole cyc tenure.
// Optional no-ack watchdog is built when WB_ARB_TIMEOUT_EN is defined (threshold TIMEOUT_CYCLES).
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_ck,
  input  logic        i_rb,
  // master 0: instruction fetch
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [3:0]  i_m0_sel,
  input  logic [29:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  output logic [31:0] o_m0_dat,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  // master 1: load/store
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [3:0]  i_m1_sel,
  input  logic [29:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  output logic [31:0] o_m1_dat,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  // slave side
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [29:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  logic   last;      // most recently granted master; the other one wins a tie
  logic   req0, req1;
  logic   fire0, fire1;
  logic   end0, end1;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT_CYCLES must be in 2..255");
  end

  assign req0 = i_m0_cyc & i_m0_stb;
  assign req1 = i_m1_cyc & i_m1_stb;

  // A tenure ends when the owner drops cyc or the watchdog terminates it.
  assign end0 = (state == GNT0) && (!i_m0_cyc || fire0);
  assign end1 = (state == GNT1) && (!i_m1_cyc || fire1);

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_cnt;

  assign fire0 = (state == GNT0) && i_m0_stb && !i_wb_ack && (wd_cnt == WD_LAST);
  assign fire1 = (state == GNT1) && i_m1_stb && !i_wb_ack && (wd_cnt == WD_LAST);

  always_ff @(posedge i_ck or negedge i_rb) begin
    if (!i_rb) begin
      wd_cnt <= 8'd0;
    end else if (o_wb_stb && !i_wb_ack && !end0 && !end1) begin
      wd_cnt <= wd_cnt + 8'd1;
    end else begin
      wd_cnt <= 8'd0;
    end
  end
`else
  assign fire0 = 1'b0;
  assign fire1 = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_ck or negedge i_rb) begin
    if (!i_rb) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 && (!req1 || last)) state <= GNT0;
          else if (req1)               state <= GNT1;
        end
        GNT0: begin
          if (end0) begin
            state <= req1 ? GNT1 : IDLE;
            last  <= 1'b0;
          end
        end
        GNT1: begin
          if (end1) begin
            state <= req0 ? GNT0 : IDLE;
            last  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_we  = 1'b0;
    o_wb_sel = 4'h0;
    o_wb_adr = 30'h0;
    o_wb_dat = 32'h0;
    unique case (state)
      GNT0: begin
        o_wb_cyc = i_m0_cyc;
        o_wb_stb = i_m0_stb;
        o_wb_we  = i_m0_we;
        o_wb_sel = i_m0_sel;
        o_wb_adr = i_m0_adr;
        o_wb_dat = i_m0_dat;
      end
      GNT1: begin
        o_wb_cyc = i_m1_cyc;
        o_wb_stb = i_m1_stb;
        o_wb_we  = i_m1_we;
        o_wb_sel = i_m1_sel;
        o_wb_adr = i_m1_adr;
        o_wb_dat = i_m1_dat;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the granted master's ack/err qualifies it.
  assign o_m0_dat = i_wb_dat;
  assign o_m1_dat = i_wb_dat;
  assign o_m0_ack = (state == GNT0) && i_m0_stb && i_wb_ack;
  assign o_m1_ack = (state == GNT1) && i_m1_stb && i_wb_ack;
  assign o_m0_err = fire0;
  assign o_m1_err = fire1;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m with a behavioural single-port memory slave.
// Watchdog expectations follow WB_ARB_TIMEOUT_EN; the DUT is built with TIMEOUT_CYCLES=4.
module tb_wb_arbiter_2m;

  logic        ck = 1'b0;
  logic        rb;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [29:0] m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_ack;

  int n_cmp = 0;
  int n_bad = 0;

  // slave model: writes ack in the stb cycle, reads one cycle later; nak suppresses ack
  bit          nak = 1'b0;
  bit          rd_pend;
  bit [255:0]  wr_flag;
  logic [31:0] mem [256];

  always #5 ck = ~ck;

  function automatic logic [31:0] exp_word(input logic [29:0] a);
    return 32'hA5A5_0000 | {24'h0, a[7:0]};
  endfunction

  assign wb_ack   = !nak && wb_cyc && wb_stb && (wb_we || rd_pend);
  assign wb_dat_i = wr_flag[wb_adr[7:0]] ? mem[wb_adr[7:0]] : exp_word(wb_adr);

  always_ff @(posedge ck) begin
    rd_pend <= wb_cyc && wb_stb && !wb_we && !rd_pend && !nak;
    if (wb_ack && wb_we) begin
      mem[wb_adr[7:0]]     <= wb_dat_o;
      wr_flag[wb_adr[7:0]] <= 1'b1;
    end
  end

  wb_arbiter_2m #(.TIMEOUT_CYCLES(4)) dut (
    .i_ck(ck), .i_rb(rb),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_sel(m0_sel),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat),
    .o_m0_dat(m0_dat_o), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_sel(m1_sel),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat),
    .o_m1_dat(m1_dat_o), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_sel(wb_sel),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat_o),
    .i_wb_dat(wb_dat_i), .i_wb_ack(wb_ack)
  );

  task automatic set_m0(input bit cyc, input bit stb, input bit we,
                        input logic [29:0] adr, input logic [31:0] dat);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_sel = 4'hF; m0_adr = adr; m0_dat = dat;
  endtask

  task automatic set_m1(input bit cyc, input bit stb, input bit we,
                        input logic [29:0] adr, input logic [31:0] dat);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_sel = 4'hF; m1_adr = adr; m1_dat = dat;
  endtask

  // inputs change 1 unit after the rising edge, outputs are sampled on the falling edge
  task automatic drive_slot();
    @(posedge ck); #1;
  endtask

  task automatic release_all();
    drive_slot();
    set_m0(0, 0, 0, 30'h0, 32'h0);
    set_m1(0, 0, 0, 30'h0, 32'h0);
    repeat (2) drive_slot();
  endtask

  task automatic test_reset();
    rb = 1'b0;
    set_m0(1, 1, 0, 30'h100, 32'h0);
    set_m1(1, 1, 0, 30'h200, 32'h0);
    @(negedge ck);
    n_cmp++;
    if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o} !== 69'h0) begin
      n_bad++;
      $display("FAIL reset_wb_outputs: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, required all 0",
               wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o);
    end
    n_cmp++;
    if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ack_err: got ack0/ack1/err0/err1=%b, required 0000",
               {m0_ack, m1_ack, m0_err, m1_err});
    end
    n_cmp++;
    if (m0_dat_o !== wb_dat_i || m1_dat_o !== wb_dat_i) begin
      n_bad++;
      $display("FAIL reset_dat_broadcast: got %h/%h, required %h", m0_dat_o, m1_dat_o, wb_dat_i);
    end
    drive_slot();
    rb = 1'b1;
    @(negedge ck);
    n_cmp++;
    if (wb_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_grant_latency: got o_wb_stb=%b before first edge, required 0", wb_stb);
    end
    drive_slot();
    @(negedge ck);
    n_cmp++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_adr !== 30'h100) begin
      n_bad++;
      $display("FAIL reset_first_grant: got cyc=%b stb=%b adr=%h, required 1 1 100",
               wb_cyc, wb_stb, wb_adr);
    end
    drive_slot();
    @(negedge ck);
    n_cmp++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_ack: got ack0=%b ack1=%b, required 1 0", m0_ack, m1_ack);
    end
    release_all();
  endtask

  task automatic test_single_write();
    drive_slot();
    set_m1(1, 1, 1, 30'h10, 32'hDEAD_BEEF);
    @(negedge ck);
    n_cmp++;
    if (wb_stb !== 1'b0) begin
      n_bad++;
      $display("FAIL write_latency: got o_wb_stb=%b in request cycle, required 0", wb_stb);
    end
    drive_slot();
    @(negedge ck);
    n_cmp++;
    if (wb_stb !== 1'b1 || wb_we !== 1'b1 || wb_adr !== 30'h10 || wb_dat_o !== 32'hDEAD_BEEF ||
        wb_sel !== 4'hF) begin
      n_bad++;
      $display("FAIL write_mux: got stb=%b we=%b adr=%h dat=%h sel=%h, required 1 1 10 deadbeef f",
               wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel);
    end
    n_cmp++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL write_ack: got ack1=%b ack0=%b, required 1 0", m1_ack, m0_ack);
    end
    drive_slot();
    set_m1(1, 1, 0, 30'h10, 32'h0);
    @(negedge ck);
    n_cmp++;
    if (m1_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL read_first_cycle: got ack1=%b, required 0", m1_ack);
    end
    drive_slot();
    @(negedge ck);
    n_cmp++;
    if (m1_ack !== 1'b1 || m1_dat_o !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL read_back: got ack1=%b dat=%h, required 1 deadbeef", m1_ack, m1_dat_o);
    end
    release_all();
  endtask

  task automatic test_contention();
    int rem0, rem1, acks, last_c;
    bit exp_m, a0, a1;
    logic [1:0] want;
    rem0 = 4; rem1 = 4; acks = 0; last_c = 0; exp_m = 1'b0;
    drive_slot();
    set_m0(1, 1, 0, 30'h20, 32'h0);
    set_m1(1, 1, 0, 30'h30, 32'h0);
    for (int c = 0; c < 80 && acks < 8; c++) begin
      @(negedge ck);
      a0 = m0_ack;
      a1 = m1_ack;
      if (a0 || a1) begin
        want = exp_m ? 2'b10 : 2'b01;
        n_cmp++;
        if ({a1, a0} !== want) begin
          n_bad++;
          $display("FAIL contention_order: tenure %0d got ack1/ack0=%b, required %b",
                   acks, {a1, a0}, want);
        end
        n_cmp++;
        if ((a1 ? m1_dat_o : m0_dat_o) !== exp_word(a1 ? m1_adr : m0_adr)) begin
          n_bad++;
          $display("FAIL contention_data: tenure %0d got %h, required %h",
                   acks, a1 ? m1_dat_o : m0_dat_o, exp_word(a1 ? m1_adr : m0_adr));
        end
        if (acks > 0) begin
          n_cmp++;
          if (c - last_c != 3) begin
            n_bad++;
            $display("FAIL contention_spacing: tenure %0d got %0d cycles between acks, required 3",
                     acks, c - last_c);
          end
        end
        last_c = c;
        acks++;
        exp_m = !exp_m;
      end
      drive_slot();
      if (a0) begin
        m0_cyc = 1'b0; m0_stb = 1'b0; rem0--;
      end else if (!m0_cyc && rem0 > 0) begin
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 30'h20 + 30'(4 - rem0);
      end
      if (a1) begin
        m1_cyc = 1'b0; m1_stb = 1'b0; rem1--;
      end else if (!m1_cyc && rem1 > 0) begin
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 30'h30 + 30'(4 - rem1);
      end
    end
    n_cmp++;
    if (acks != 8) begin
      n_bad++;
      $display("FAIL contention_count: got %0d acks within budget, required 8", acks);
    end
    release_all();
  endtask

  task automatic test_held_grant();
    int bad_gap;
    drive_slot();
    set_m0(1, 1, 0, 30'h40, 32'h0);
    set_m1(1, 1, 0, 30'h50, 32'h0);
    repeat (2) drive_slot();
    @(negedge ck);
    n_cmp++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL held_first_ack: got ack0=%b ack1=%b, required 1 0", m0_ack, m1_ack);
    end
    drive_slot();
    m0_stb = 1'b0;
    bad_gap = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      if (wb_cyc !== 1'b1 || wb_stb !== 1'b0 || wb_adr !== 30'h40 || m1_ack !== 1'b0) bad_gap++;
      drive_slot();
    end
    n_cmp++;
    if (bad_gap != 0) begin
      n_bad++;
      $display("FAIL held_gap: got %0d gap cycles not holding M0 with stb low, required 0", bad_gap);
    end
    m0_stb = 1'b1;
    m0_adr = 30'h44;
    drive_slot();
    @(negedge ck);
    n_cmp++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_dat_o !== exp_word(30'h44)) begin
      n_bad++;
      $display("FAIL held_second_read: got ack0=%b ack1=%b dat=%h, required 1 0 %h",
               m0_ack, m1_ack, m0_dat_o, exp_word(30'h44));
    end
    drive_slot();
    set_m0(0, 0, 0, 30'h0, 32'h0);
    @(negedge ck);
    n_cmp++;
    if (wb_cyc !== 1'b0 || m1_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL held_release: got cyc=%b ack1=%b, required 0 0", wb_cyc, m1_ack);
    end
    drive_slot();
    @(negedge ck);
    n_cmp++;
    if (wb_stb !== 1'b1 || wb_adr !== 30'h50) begin
      n_bad++;
      $display("FAIL held_handoff: got stb=%b adr=%h, required 1 50", wb_stb, wb_adr);
    end
    drive_slot();
    @(negedge ck);
    n_cmp++;
    if (m1_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL held_m1_ack: got ack1=%b, required 1", m1_ack);
    end
    release_all();
  endtask

  task automatic test_reset_mid_read();
    drive_slot();
    set_m0(1, 1, 0, 30'h60, 32'h0);
    drive_slot();
    @(negedge ck);
    n_cmp++;
    if (wb_stb !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_stb: got o_wb_stb=%b, required 1", wb_stb);
    end
    drive_slot();
    rb = 1'b0;
    @(negedge ck);
    n_cmp++;
    if ({wb_cyc, wb_stb, m0_ack, m0_err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL midrst_abort: got cyc/stb/ack0/err0=%b, required 0000",
               {wb_cyc, wb_stb, m0_ack, m0_err});
    end
    drive_slot();
    rb = 1'b1;
    @(negedge ck);
    n_cmp++;
    if (wb_stb !== 1'b0 || m0_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_idle: got stb=%b ack0=%b, required 0 0", wb_stb, m0_ack);
    end
    drive_slot();
    drive_slot();
    @(negedge ck);
    n_cmp++;
    if (m0_ack !== 1'b1 || m0_dat_o !== exp_word(30'h60)) begin
      n_bad++;
      $display("FAIL midrst_restart: got ack0=%b dat=%h, required 1 %h",
               m0_ack, m0_dat_o, exp_word(30'h60));
    end
    release_all();
  endtask

  task automatic test_watchdog();
    int bad_early;
    drive_slot();
    nak = 1'b1;
    set_m0(1, 1, 0, 30'h70, 32'h0);
    drive_slot();
    set_m1(1, 1, 0, 30'h74, 32'h0);
    bad_early = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge ck);
      if (wb_stb !== 1'b1 || wb_adr !== 30'h70 || m0_err !== 1'b0 || m0_ack !== 1'b0) bad_early++;
      drive_slot();
    end
    n_cmp++;
    if (bad_early != 0) begin
      n_bad++;
      $display("FAIL wd_early: got %0d of stb cycles 1-3 wrong, required 0", bad_early);
    end
    @(negedge ck);
`ifdef WB_ARB_TIMEOUT_EN
    n_cmp++;
    if (m0_err !== 1'b1 || m0_ack !== 1'b0 || m1_err !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_err_pulse: got err0=%b ack0=%b err1=%b, required 1 0 0",
               m0_err, m0_ack, m1_err);
    end
    drive_slot();
    set_m0(0, 0, 0, 30'h0, 32'h0);
    nak = 1'b0;
    @(negedge ck);
    n_cmp++;
    if (wb_stb !== 1'b1 || wb_adr !== 30'h74 || m0_err !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_handoff: got stb=%b adr=%h err0=%b, required 1 74 0", wb_stb, wb_adr, m0_err);
    end
    drive_slot();
    @(negedge ck);
    n_cmp++;
    if (m1_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_m1_ack: got ack1=%b, required 1", m1_ack);
    end
`else
    n_cmp++;
    if (m0_err !== 1'b0 || wb_stb !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_disabled_4th: got err0=%b stb=%b, required 0 1", m0_err, wb_stb);
    end
    bad_early = 0;
    for (int i = 0; i < 110; i++) begin
      drive_slot();
      @(negedge ck);
      if (wb_stb !== 1'b1 || wb_adr !== 30'h70 || m0_err !== 1'b0 || m1_ack !== 1'b0) bad_early++;
    end
    n_cmp++;
    if (bad_early != 0) begin
      n_bad++;
      $display("FAIL wd_disabled_stall: got %0d of 110 cycles not stalled on M0, required 0", bad_early);
    end
    drive_slot();
    nak = 1'b0;
    drive_slot();
    @(negedge ck);
    n_cmp++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_disabled_recover: got ack0=%b ack1=%b, required 1 0", m0_ack, m1_ack);
    end
`endif
    release_all();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time budget, required completion");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_held_grant();
    test_reset_mid_read();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
